// File: rtl/gtx_usrclk_monitor_if.sv
// Bundle between the usrclk monitor and its user: divided toggle inputs,
// loss-clear/readback controls, and the qualified-clock status outputs.
interface gtx_usrclk_monitor_if #(
  parameter int CHNL_NUM = 8,
  parameter int CNT_W    = 16
);
  localparam int SEL_W = $clog2(2 * CHNL_NUM);

  logic [CHNL_NUM-1:0] tx_clk_tog;
  logic [CHNL_NUM-1:0] rx_clk_tog;
  logic                clr_loss;
  logic [SEL_W-1:0]    cnt_sel;
  logic [CHNL_NUM-1:0] tx_clk_ok;
  logic [CHNL_NUM-1:0] rx_clk_ok;
  logic [CHNL_NUM-1:0] tx_loss;
  logic [CHNL_NUM-1:0] rx_loss;
  logic [CNT_W-1:0]    cnt_rd;
  logic                win_done;

  modport master (
    output tx_clk_tog, rx_clk_tog, clr_loss, cnt_sel,
    input  tx_clk_ok, rx_clk_ok, tx_loss, rx_loss, cnt_rd, win_done
  );

  modport slave (
    input  tx_clk_tog, rx_clk_tog, clr_loss, cnt_sel,
    output tx_clk_ok, rx_clk_ok, tx_loss, rx_loss, cnt_rd, win_done
  );
endinterface

// File: rtl/gtx_usrclk_monitor.sv
// GTX usrclk health monitor: counts divided-clock toggle edges per fixed window
// in the system clock domain and qualifies each usrclk with a lock FSM.
module gtx_usrclk_monitor #(
  parameter int    CHNL_NUM = 8,
  parameter string BUFG_NUM = "single",
  parameter int    WIN_CYC  = 16000,
  parameter int    CNT_W    = 16,
  parameter int    EXP_CNT  = 1250,
  parameter int    TOL      = 8,
  parameter int    LOCK_WIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  gtx_usrclk_monitor_if.slave mon
);
  localparam int NMON  = 2 * CHNL_NUM;
  localparam int SEL_W = $clog2(NMON);
  localparam int WIN_W = $clog2(WIN_CYC);
  localparam int CW1   = CNT_W + 1;
  localparam bit SINGLE = (BUFG_NUM == "single");

  localparam logic [CW1-1:0]      LO  = (EXP_CNT > TOL) ? CW1'(EXP_CNT - TOL) : '0;
  localparam logic [CW1-1:0]      HI  = CW1'(EXP_CNT + TOL);
  localparam logic [CNT_W-1:0]    SAT = '1;
  localparam logic [CHNL_NUM-1:0] RX_MASK = SINGLE ? CHNL_NUM'(1) : {CHNL_NUM{1'b1}};

  typedef enum logic [1:0] {ST_DOWN = 2'd0, ST_VERIFY = 2'd1, ST_UP = 2'd2} st_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != SAT)) return v + 1'b1;
    return v;
  endfunction

  // A saturated count may hide any number of extra edges, so it never qualifies.
  function automatic logic in_window(input logic [CNT_W-1:0] c);
    logic [CW1-1:0] cx;
    cx = {1'b0, c};
    return (c != SAT) && (cx >= LO) && (cx <= HI);
  endfunction

  logic [WIN_W-1:0]    win_q;
  logic                done_q;
  logic                win_end;
  logic [CHNL_NUM-1:0] rx_used;
  logic [NMON-1:0]     tog;
  logic [CNT_W-1:0]    cnt_arr [NMON];
  logic [NMON-1:0]     ok_vec;
  logic [NMON-1:0]     loss_vec;

  assign win_end = (win_q == WIN_W'(WIN_CYC - 1));
  assign rx_used = mon.rx_clk_tog & RX_MASK;
  assign tog     = {rx_used, mon.tx_clk_tog};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      done_q <= 1'b0;
    end else begin
      win_q  <= win_end ? '0 : win_q + 1'b1;
      done_q <= win_end;
    end
  end

  // Monitors 0..CHNL_NUM-1 watch tx, CHNL_NUM..NMON-1 watch rx.
  for (genvar m = 0; m < NMON; m++) begin : g_mon
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] edge_q;
    logic [CNT_W-1:0] edge_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       good_q;
    st_e              st_q;
    logic             ok_q;
    logic             loss_q;
    logic             good;
    logic             set_loss;

    // The closing cycle's edge is folded in before the count is latched and judged.
    assign edge_d   = sat_inc(edge_q, sync_q[1] ^ sync_q[2]);
    assign good     = in_window(edge_d);
    assign set_loss = win_end && (st_q == ST_UP) && !good;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        edge_q <= '0;
        cnt_q  <= '0;
        good_q <= '0;
        st_q   <= ST_DOWN;
        ok_q   <= 1'b0;
        loss_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[1:0], tog[m]};
        loss_q <= set_loss | (loss_q & ~mon.clr_loss);
        if (win_end) begin
          edge_q <= '0;
          cnt_q  <= edge_d;
          case (st_q)
            ST_DOWN: begin
              if (good) begin
                if (LOCK_WIN == 1) begin
                  st_q <= ST_UP;
                  ok_q <= 1'b1;
                end else begin
                  st_q   <= ST_VERIFY;
                  good_q <= 8'd1;
                end
              end
            end
            ST_VERIFY: begin
              if (!good) begin
                st_q   <= ST_DOWN;
                good_q <= '0;
              end else if (good_q + 8'd1 == 8'(LOCK_WIN)) begin
                st_q   <= ST_UP;
                ok_q   <= 1'b1;
                good_q <= '0;
              end else begin
                good_q <= good_q + 8'd1;
              end
            end
            ST_UP: begin
              if (!good) begin
                st_q <= ST_DOWN;
                ok_q <= 1'b0;
              end
            end
            default: begin
              st_q   <= ST_DOWN;
              ok_q   <= 1'b0;
              good_q <= '0;
            end
          endcase
        end else begin
          edge_q <= edge_d;
        end
      end
    end

    assign cnt_arr[m]  = cnt_q;
    assign ok_vec[m]   = ok_q;
    assign loss_vec[m] = loss_q;
  end

  assign mon.tx_clk_ok = ok_vec[CHNL_NUM-1:0];
  assign mon.tx_loss   = loss_vec[CHNL_NUM-1:0];
  assign mon.rx_clk_ok = SINGLE ? {CHNL_NUM{ok_vec[CHNL_NUM]}}   : ok_vec[NMON-1:CHNL_NUM];
  assign mon.rx_loss   = SINGLE ? {CHNL_NUM{loss_vec[CHNL_NUM]}} : loss_vec[NMON-1:CHNL_NUM];
  assign mon.win_done  = done_q;

  logic [SEL_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_d;
  logic [CNT_W-1:0] rd_q;

  // Any in-range rx select folds onto rx ch0 when only that channel is monitored.
  always_comb begin
    rd_sel = mon.cnt_sel;
    if (SINGLE && (int'(mon.cnt_sel) >= CHNL_NUM) && (int'(mon.cnt_sel) < NMON))
      rd_sel = SEL_W'(CHNL_NUM);
    rd_d = '0;
    for (int m = 0; m < NMON; m++)
      if (int'(rd_sel) == m) rd_d = cnt_arr[m];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign mon.cnt_rd = rd_q;
endmodule

// File: tb/tb_gtx_usrclk_monitor.sv
// Directed bench for gtx_usrclk_monitor: one "multi" and one "single" instance
// share clock/reset; toggle inputs are generated on the falling clock edge.
module tb_gtx_usrclk_monitor;
  localparam int CH = 6;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Toggle channels: 0..5 multi tx, 6..11 multi rx, 12..17 single tx, 18..23 single rx.
  int         hp  [24];
  int         ctr [24];
  logic [23:0] lvl;

  gtx_usrclk_monitor_if #(.CHNL_NUM(CH), .CNT_W(CW)) if_m ();
  gtx_usrclk_monitor_if #(.CHNL_NUM(CH), .CNT_W(CW)) if_s ();

  gtx_usrclk_monitor #(
    .CHNL_NUM(CH), .BUFG_NUM("multi"), .WIN_CYC(96), .CNT_W(CW),
    .EXP_CNT(12), .TOL(3), .LOCK_WIN(4)
  ) dut_m (.clk(clk), .rst(rst), .mon(if_m));

  gtx_usrclk_monitor #(
    .CHNL_NUM(CH), .BUFG_NUM("single"), .WIN_CYC(96), .CNT_W(CW),
    .EXP_CNT(12), .TOL(3), .LOCK_WIN(4)
  ) dut_s (.clk(clk), .rst(rst), .mon(if_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    lvl = '0;
    for (int i = 0; i < 24; i++) ctr[i] = 0;
    if_m.tx_clk_tog = '0; if_m.rx_clk_tog = '0;
    if_s.tx_clk_tog = '0; if_s.rx_clk_tog = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 24; i++) begin
        if (hp[i] != 0) begin
          ctr[i] = ctr[i] + 1;
          if (ctr[i] >= hp[i]) begin
            ctr[i] = 0;
            lvl[i] = ~lvl[i];
          end
        end
      end
      if_m.tx_clk_tog = lvl[5:0];
      if_m.rx_clk_tog = lvl[11:6];
      if_s.tx_clk_tog = lvl[17:12];
      if_s.rx_clk_tog = lvl[23:18];
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_hp(input int idx, input int v);
    hp[idx]  = v;
    ctr[idx] = 0;
  endtask

  task automatic wait_win(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (if_m.win_done !== 1'b1 && n < 200);
    chk(tag, 32'(if_m.win_done), 32'h1);
  endtask

  // Negedges from reset release to the first win_done pulse.
  task automatic first_win(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (if_m.win_done !== 1'b1 && n < 300);
    chk(tag, n, 96);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if_m.clr_loss = 1'b0; if_m.cnt_sel = '0;
    if_s.clr_loss = 1'b0; if_s.cnt_sel = '0;
    for (int i = 0; i < 24; i++) hp[i] = (i >= 19) ? 0 : 8;

    repeat (3) @(negedge clk);
    chk("rst_m_tx_ok",   32'(if_m.tx_clk_ok), 32'h0);
    chk("rst_m_rx_ok",   32'(if_m.rx_clk_ok), 32'h0);
    chk("rst_m_rx_loss", 32'(if_m.rx_loss),   32'h0);
    chk("rst_m_cnt_rd",  32'(if_m.cnt_rd),    32'h0);
    chk("rst_win_done",  32'(if_m.win_done),  32'h0);
    chk("rst_s_rx_ok",   32'(if_s.rx_clk_ok), 32'h0);

    rst = 1'b0;
    first_win("w1_latency");
    chk("w1_tx_ok", 32'(if_m.tx_clk_ok), 32'h0);
    wait_win("w2");
    chk("w2_tx_ok", 32'(if_m.tx_clk_ok), 32'h0);
    wait_win("w3");
    chk("w3_tx_ok", 32'(if_m.tx_clk_ok), 32'h0);
    wait_win("w4");
    chk("w4_m_tx_ok", 32'(if_m.tx_clk_ok), 32'h3f);
    chk("w4_m_rx_ok", 32'(if_m.rx_clk_ok), 32'h3f);
    chk("w4_s_tx_ok", 32'(if_s.tx_clk_ok), 32'h3f);
    chk("w4_s_rx_ok", 32'(if_s.rx_clk_ok), 32'h3f);

    // Readback: 96 cycles / 8-cycle half period = 12 edges.
    if_m.cnt_sel = 4'd0;
    if_s.cnt_sel = 4'd10;
    @(negedge clk);
    chk("rd_m_tx0", 32'(if_m.cnt_rd), 32'd12);
    chk("rd_s_rx4_is_ch0", 32'(if_s.cnt_rd), 32'd12);
    if_m.cnt_sel = 4'd9;
    if_s.cnt_sel = 4'd13;
    @(negedge clk);
    chk("rd_m_rx3", 32'(if_m.cnt_rd), 32'd12);
    chk("rd_s_out_of_range", 32'(if_s.cnt_rd), 32'd0);
    if_m.cnt_sel = 4'd13;
    #1;
    chk("rd_latency_hold", 32'(if_m.cnt_rd), 32'd12);
    @(negedge clk);
    chk("rd_m_out_of_range", 32'(if_m.cnt_rd), 32'd0);

    set_hp(9, 0);
    set_hp(18, 0);
    wait_win("w5");
    chk("w5_m_rx_ok",   32'(if_m.rx_clk_ok), 32'h37);
    chk("w5_m_rx_loss", 32'(if_m.rx_loss),   32'h08);
    chk("w5_m_tx_ok",   32'(if_m.tx_clk_ok), 32'h3f);
    chk("w5_m_tx_loss", 32'(if_m.tx_loss),   32'h00);
    chk("w5_s_rx_ok",   32'(if_s.rx_clk_ok), 32'h00);
    chk("w5_s_rx_loss", 32'(if_s.rx_loss),   32'h3f);
    chk("w5_s_tx_ok",   32'(if_s.tx_clk_ok), 32'h3f);

    set_hp(9, 8);
    wait_win("w6");
    chk("w6_m_rx_ok", 32'(if_m.rx_clk_ok), 32'h37);
    set_hp(9, 6);
    wait_win("w7");
    chk("w7_m_rx_ok",   32'(if_m.rx_clk_ok), 32'h37);
    chk("w7_m_rx_loss", 32'(if_m.rx_loss),   32'h08);
    if_m.cnt_sel = 4'd9;
    @(negedge clk);
    chk("w7_rd_saturated", 32'(if_m.cnt_rd), 32'd15);
    set_hp(9, 8);
    wait_win("w8");
    wait_win("w9");
    wait_win("w10");
    chk("w10_relock_pending", 32'(if_m.rx_clk_ok), 32'h37);
    wait_win("w11");
    chk("w11_relocked", 32'(if_m.rx_clk_ok), 32'h3f);

    if_m.clr_loss = 1'b1;
    @(negedge clk);
    if_m.clr_loss = 1'b0;
    chk("clr_alone_1", 32'(if_m.rx_loss), 32'h00);
    set_hp(9, 0);
    repeat (94) @(negedge clk);
    if_m.clr_loss = 1'b1;
    @(negedge clk);
    if_m.clr_loss = 1'b0;
    chk("w12_align",       32'(if_m.win_done),  32'h1);
    chk("w12_set_wins",    32'(if_m.rx_loss),   32'h08);
    chk("w12_m_rx_ok",     32'(if_m.rx_clk_ok), 32'h37);
    if_m.clr_loss = 1'b1;
    @(negedge clk);
    if_m.clr_loss = 1'b0;
    chk("clr_alone_2",     32'(if_m.rx_loss),   32'h00);
    chk("s_loss_untouched", 32'(if_s.rx_loss),  32'h3f);

    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_tx_ok",  32'(if_m.tx_clk_ok), 32'h0);
    chk("mid_rst_s_tx_ok",  32'(if_s.tx_clk_ok), 32'h0);
    chk("mid_rst_s_rx_loss", 32'(if_s.rx_loss),  32'h0);
    chk("mid_rst_cnt_rd",   32'(if_m.cnt_rd),    32'h0);
    set_hp(9, 8);
    set_hp(18, 8);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first_win("r1_latency");
    chk("r1_tx_ok", 32'(if_m.tx_clk_ok), 32'h0);
    wait_win("r2");
    wait_win("r3");
    chk("r3_tx_ok", 32'(if_m.tx_clk_ok), 32'h0);
    wait_win("r4");
    chk("r4_m_tx_ok",   32'(if_m.tx_clk_ok), 32'h3f);
    chk("r4_m_rx_ok",   32'(if_m.rx_clk_ok), 32'h3f);
    chk("r4_s_rx_ok",   32'(if_s.rx_clk_ok), 32'h3f);
    chk("r4_m_rx_loss", 32'(if_m.rx_loss),   32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
